// File: rtl/replay_ctrl_pkg.sv
// Shared definitions for the record/replay controller: FSM encoding and buffer sizing.
package replay_ctrl_pkg;

  typedef enum logic [2:0] {
    StRec,
    StRd,
    StSend,
    StWaitTx,
    StAbort
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/replay_ram.sv
// Simple dual-port word buffer: one write port, one registered read port, no reset.
module replay_ram
  import replay_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/replay_ctrl.sv
// Records received words into a buffer, then replays them to the transmitter on a key press,
// once or repeatedly, with abort on a second press.
module replay_ctrl
  import replay_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_flag,
  input  logic              key_state,
  input  logic              loop_mode,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  output logic [DATA_W-1:0] tx_data,
  output logic              send_en,
  output logic [ADDR_W:0]   count,
  output logic              playing,
  output logic              overflow,
  output logic              rx_drop,
  output logic              led
);

  localparam int unsigned    DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_e              state_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     rd_ptr_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                send_en_q;
  logic                overflow_q;
  logic                rx_drop_q;
  logic                ack_pending_q;
  logic [DATA_W-1:0]   ram_q;

  logic press;
  logic buf_full;
  logic wr_en;

  assign press    = key_flag & ~key_state;
  assign buf_full = (count_q == DEPTH_CNT);
  assign wr_en    = (state_q == StRec) && rx_done && !buf_full;

  replay_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(count_q[ADDR_W-1:0]),
    .wdata(rx_data),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRec;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      tx_data_q     <= '0;
      send_en_q     <= 1'b0;
      overflow_q    <= 1'b0;
      rx_drop_q     <= 1'b0;
      ack_pending_q <= 1'b0;
    end else begin
      send_en_q <= 1'b0;
      rx_drop_q <= rx_done && (state_q != StRec);
      if (tx_done) begin
        ack_pending_q <= 1'b0;
      end

      unique case (state_q)
        StRec: begin
          if (rx_done) begin
            if (!buf_full) begin
              count_q <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
          // A word arriving with the press is already written and joins the playback.
          if (press && ((count_q != '0) || wr_en)) begin
            rd_ptr_q <= '0;
            state_q  <= StRd;
          end
        end

        StRd: begin
          if (press) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            state_q    <= StRec;
          end else begin
            state_q <= StSend;
          end
        end

        StSend: begin
          tx_data_q     <= ram_q;
          send_en_q     <= 1'b1;
          ack_pending_q <= 1'b1;
          rd_ptr_q      <= rd_ptr_q + 1'b1;
          state_q       <= press ? StAbort : StWaitTx;
        end

        StWaitTx: begin
          if (tx_done) begin
            if (press) begin
              count_q    <= '0;
              overflow_q <= 1'b0;
              rd_ptr_q   <= '0;
              state_q    <= StRec;
            end else if (rd_ptr_q < count_q) begin
              state_q <= StRd;
            end else if (loop_mode) begin
              rd_ptr_q <= '0;
              state_q  <= StRd;
            end else begin
              count_q    <= '0;
              overflow_q <= 1'b0;
              rd_ptr_q   <= '0;
              state_q    <= StRec;
            end
          end else if (press) begin
            state_q <= StAbort;
          end
        end

        StAbort: begin
          // Only hold off while a transmitted word is still unacknowledged.
          if (tx_done || !ack_pending_q) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            state_q    <= StRec;
          end
        end

        default: state_q <= StRec;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign send_en  = send_en_q;
  assign count    = count_q;
  assign playing  = (state_q != StRec);
  assign led      = playing;
  assign overflow = overflow_q;
  assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// Directed and randomized checks of replay_ctrl against a queue-based record/playback model.
module tb_replay_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              key_flag = 1'b0;
  logic              key_state = 1'b1;
  logic              loop_mode = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_done = 1'b0;
  logic              tx_done = 1'b0;
  logic [DATA_W-1:0] tx_data;
  logic              send_en;
  logic [ADDR_W:0]   count;
  logic              playing;
  logic              overflow;
  logic              rx_drop;
  logic              led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_sends = 0;
  int last_done = -100;
  int tx_lat = 20;
  int epoch = 0;
  bit prev_send = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  replay_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_flag (key_flag),
    .key_state(key_state),
    .loop_mode(loop_mode),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .send_en  (send_en),
    .count    (count),
    .playing  (playing),
    .overflow (overflow),
    .rx_drop  (rx_drop),
    .led      (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every transmit request is logged, must be one cycle wide and spaced from the
  // previous acknowledge.
  initial forever begin
    @(posedge clk);
    #1;
    if (send_en) begin
      check("send_one_cycle", 32'(prev_send), 0);
      check("send_gap", 32'((cyc - last_done) >= 3), 1);
      got_q.push_back(tx_data);
      n_sends++;
    end
    prev_send = send_en;
  end

  // Transmitter model: acknowledges each request tx_lat cycles later.
  initial forever begin
    logic [7:0] hold;
    int ep;
    @(posedge clk);
    #1;
    if (send_en) begin
      hold = tx_data;
      ep = epoch;
      repeat (tx_lat) begin
        @(posedge clk);
        #1;
      end
      tx_done = 1'b1;
      last_done = cyc;
      if (ep == epoch) check("tx_data_stable", 32'(tx_data), 32'(hold));
      @(posedge clk);
      #1;
      tx_done = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rx(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic press();
    key_flag = 1'b1;
    key_state = 1'b0;
    step();
    key_flag = 1'b0;
    key_state = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (playing && i < budget) begin
      step();
      i++;
    end
    check("idle_timeout", 32'(playing), 0);
  endtask

  task automatic wait_sends(input int target, input int budget);
    int i = 0;
    while (n_sends < target && i < budget) begin
      step();
      i++;
    end
    check("send_timeout", 32'(n_sends >= target), 1);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int base;
    int n;
    int dw;
    logic [7:0] d;

    step();
    step();
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_send_en", 32'(send_en), 0);
    check("rst_count", 32'(count), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_led", 32'(led), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rx_drop", 32'(rx_drop), 0);
    reset = 1'b0;
    step();

    // Press with empty buffer is ignored.
    base = n_sends;
    press();
    repeat (100) step();
    check("empty_no_send", 32'(n_sends - base), 0);
    check("empty_playing", 32'(playing), 0);

    // Basic record/replay; last word arrives together with the press.
    tx_lat = 20;
    got_q.delete();
    exp_q = '{8'h11, 8'h22, 8'h33};
    rx(8'h11);
    rx(8'h22);
    rx_data = 8'h33;
    rx_done = 1'b1;
    key_flag = 1'b1;
    key_state = 1'b0;
    step();
    rx_done = 1'b0;
    key_flag = 1'b0;
    key_state = 1'b1;
    check("basic_count", 32'(count), 3);
    check("basic_playing", 32'(playing), 1);
    check("basic_led", 32'(led), 1);
    wait_idle(500);
    compare_seq("basic");
    check("basic_count_clr", 32'(count), 0);

    // Overflow: 5 words into a 4-word buffer.
    tx_lat = 3;
    got_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      d = 8'($urandom);
      rx(d);
      if (i <= DEPTH) exp_q.push_back(d);
      check($sformatf("ovf_count%0d", i), 32'(count), 32'((i > DEPTH) ? DEPTH : i));
      check($sformatf("ovf_flag%0d", i), 32'(overflow), 32'(i > DEPTH));
    end
    // Key release event is not a press.
    key_flag = 1'b1;
    key_state = 1'b1;
    step();
    key_flag = 1'b0;
    check("release_ignored", 32'(playing), 0);
    press();
    wait_idle(500);
    compare_seq("ovf");
    check("ovf_clr", 32'(overflow), 0);
    check("ovf_count_clr", 32'(count), 0);

    // Loop mode: four passes, abort while the 8th word is in flight.
    tx_lat = 20;
    loop_mode = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
    end
    rx(8'hA5);
    rx(8'h5A);
    base = n_sends;
    press();
    wait_sends(base + 8, 2000);
    press();
    wait_idle(500);
    repeat (60) step();
    compare_seq("loop");
    check("loop_stopped", 32'(n_sends - base), 8);
    check("loop_count_clr", 32'(count), 0);
    loop_mode = 1'b0;

    // Randomized recordings with dropped rx words during playback.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      tx_lat = $urandom_range(1, 8);
      got_q.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        rx(d);
        if (i < DEPTH) exp_q.push_back(d);
      end
      check($sformatf("rnd%0d_count", it), 32'(count), 32'((n > DEPTH) ? DEPTH : n));
      check($sformatf("rnd%0d_ovf", it), 32'(overflow), 32'(n > DEPTH));
      press();
      dw = $urandom_range(0, 2);
      repeat (dw) step();
      rx(8'($urandom));
      check($sformatf("rnd%0d_drop", it), 32'(rx_drop), 1);
      check($sformatf("rnd%0d_cnt_hold", it), 32'(count), 32'((n > DEPTH) ? DEPTH : n));
      step();
      check($sformatf("rnd%0d_drop_pulse", it), 32'(rx_drop), 0);
      wait_idle(1000);
      compare_seq($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_count_clr", it), 32'(count), 0);
      check($sformatf("rnd%0d_ovf_clr", it), 32'(overflow), 0);
    end

    // Reset while waiting for an acknowledge.
    tx_lat = 20;
    for (int i = 0; i < 5; i++) rx(8'($urandom));
    check("rst_pre_ovf", 32'(overflow), 1);
    base = n_sends;
    press();
    wait_sends(base + 1, 200);
    repeat (3) step();
    epoch++;
    reset = 1'b1;
    rx_data = 8'hC3;
    rx_done = 1'b1;
    step();
    reset = 1'b0;
    rx_done = 1'b0;
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_send_en", 32'(send_en), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_playing", 32'(playing), 0);
    check("mid_rst_led", 32'(led), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_rx_drop", 32'(rx_drop), 0);
    repeat (60) step();
    check("mid_rst_no_send", 32'(n_sends - base), 1);
    check("mid_rst_idle", 32'(playing), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
